ifetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of decode and the immediate sign-extension stage.
- Holds the PC and fetches 32-bit words from instruction memory over a req/gnt/rvalid handshake.
- Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Supplies `instr` (full word), `opcode` (`instr[6:0]`, the instruction-type select used by sign extension) and the matching PC.
- Handles branch/jump redirects, flushing in-flight and buffered words.

---
 rtl/ifetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 32-bit words over a req/gnt/rvalid
// bus with at most one outstanding request, buffers them in a small FIFO and hands
// them to decode over valid/ready. Redirects flush both the FIFO and any in-flight word.
// FIFO_DEPTH must be 2 or 4 (power of two keeps pointer wrap free); RESET_PC[1:0] must be 0.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // Instruction memory bus
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    // Control flow redirect
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    // Decode side
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] instr_pc_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    // Address of the request currently in flight, stored alongside its data.
    logic [31:0]      req_pc_q, req_pc_d;

    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Registered head of the FIFO as seen by decode.
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      instr_pc_q, instr_pc_d;

    logic             push;
    logic             pop;
    logic [CntW-1:0]  count_popped;
    logic [31:0]      redirect_target;
    logic             unused_redirect_lsb;

    assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // A response landing together with a redirect belongs to the old path: drop it.
    assign push = (state_q == StResp) && imem_rvalid_i && !redirect_i;
    assign pop  = valid_q && instr_ready_i;
    // valid_q mirrors count_q != 0, so this never underflows.
    assign count_popped = count_q - CntW'(pop);

    // Fetch FSM: request issue, response wait, and redirect handling.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        imem_req_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Nothing outstanding here, so the space check is on the count alone.
                if (count_q < Depth) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'(PC_STEP);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (imem_rvalid_i) begin
                    // Another word fits if occupancy after this push stays below depth.
                    state_d = (count_popped < (Depth - CntW'(1))) ? StReq : StIdle;
                end
            end
            StFlush: begin
                if (imem_rvalid_i) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_i) begin
            pc_d = redirect_target;
            // Stay in (or enter) FLUSH only while a response is still owed to us.
            if (((state_q == StResp) && !imem_rvalid_i) ||
                ((state_q == StReq) && imem_gnt_i) ||
                ((state_q == StFlush) && !imem_rvalid_i)) begin
                state_d = StFlush;
            end else begin
                state_d = StReq;
            end
        end
    end

    assign imem_addr_o = pc_q;

    // FIFO bookkeeping and next value of the registered head.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            count_d  = count_popped + CntW'(push);
            valid_d  = (count_d != '0);
            if (count_d != '0) begin
                if (count_popped == '0) begin
                    // FIFO drains to empty this cycle, so the new head is the word arriving now.
                    instr_d    = imem_rdata_i;
                    instr_pc_d = req_pc_q;
                end else begin
                    instr_d    = fifo_instr_q[rd_ptr_d];
                    instr_pc_d = fifo_pc_q[rd_ptr_d];
                end
            end
            // When empty, the head registers keep their last contents.
        end
    end

    // FSM, PC and in-flight address registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // FIFO storage, pointers, count and the registered head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[6:0];
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a small memory responder with a grant budget and a
// programmable response latency, directed scenarios, and a scoreboard monitor that
// checks every word decode accepts against the queue of expected {pc, instr}.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (4),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_o      (instr),
        .opcode_o     (opcode),
        .instr_pc_o   (instr_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Memory contents: two fixed words at 0x0/0x4, an address-derived pattern elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0050_0093;
            32'h0000_0004: memf = 32'h00A0_0113;
            default:       memf = {a[24:0], 7'b0110011};
        endcase
    endfunction

    // Memory responder: grants while the budget allows, answers after 'lat' cycles.
    int unsigned gnt_allow = 0;
    int unsigned gnt_count = 0;
    int unsigned lat       = 1;
    int unsigned wait_cnt  = 0;
    logic        pend      = 1'b0;
    logic [31:0] paddr     = '0;

    assign imem_gnt = imem_req && (gnt_count < gnt_allow);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (wait_cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memf(paddr);
                    pend        <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
            if (imem_req && imem_gnt) begin
                gnt_count <= gnt_count + 1;
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memf(imem_addr);
                end else begin
                    pend     <= 1'b1;
                    paddr    <= imem_addr;
                    wait_cnt <= lat - 1;
                end
            end
        end
    end

    // Scoreboard monitor: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got pc %h instr %h, required no word",
                         instr_pc, instr);
            end else begin
                mon_e = sb.pop_front();
                if (instr !== mon_e.instr || opcode !== mon_e.instr[6:0] ||
                    instr_pc !== mon_e.pc) begin
                    n_err++;
                    $display("FAIL word: got pc %h instr %h opcode %b, required pc %h instr %h",
                             instr_pc, instr, opcode, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = memf(pc);
        sb.push_back(e);
    endtask

    task automatic wait_req(input int bound, input string name);
        int i = 0;
        while (!imem_req && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (!imem_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no request after %0d cycles, required imem_req", name, bound);
        end
    endtask

    task automatic wait_sb_empty(input int bound, input string name);
        int i = 0;
        while (sb.size() != 0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d words undelivered, required 0", name, sb.size());
        end
    endtask

    int unsigned g0;

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_opcode", {25'd0, opcode}, 32'd0);
        check("rst_pc", instr_pc, 32'd0);

        // Reset then stream: four words, always granted, 1-cycle response
        gnt_allow = 4;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("first_gnt", {31'd0, imem_gnt}, 32'd1);
        repeat (2) @(negedge clk);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_opcode", {25'd0, opcode}, {25'd0, 7'b0010011});
        check("first_pc", instr_pc, 32'h0);
        wait_sb_empty(60, "stream_drain");

        // Stalled grant: request and address hold at 0x10
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, 32'h10);
        end
        instr_ready = 1'b0;
        gnt_allow   = 5;
        repeat (2) @(negedge clk);
        check("post_stall_req", {31'd0, imem_req}, 32'd1);
        check("post_stall_addr", imem_addr, 32'h14);
        check("post_stall_valid", {31'd0, instr_valid}, 32'd1);
        check("post_stall_pc", instr_pc, 32'h10);

        // Async reset between grant and response
        lat       = 3;
        gnt_allow = 6;
        @(negedge clk);
        check("resp_req_low", {31'd0, imem_req}, 32'd0);
        check("resp_valid_hi", {31'd0, instr_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_pc", instr_pc, 32'h0);

        // Backpressure from reset: two words buffered, then idle
        instr_ready = 1'b0;
        lat         = 1;
        gnt_allow   = gnt_count + 3;
        g0          = gnt_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("bp_req_idle", {31'd0, imem_req}, 32'd0);
        check("bp_valid", {31'd0, instr_valid}, 32'd1);
        check("bp_instr_hold", instr, 32'h0050_0093);
        check("bp_pc_hold", instr_pc, 32'h0);
        check("bp_words_fetched", gnt_count - g0, 32'd2);
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        instr_ready = 1'b1;
        wait_req(10, "bp_resume");
        check("bp_resume_addr", imem_addr, 32'h8);
        wait_sb_empty(40, "bp_drain");

        // Redirect while the 0xC response is outstanding
        lat       = 3;
        gnt_allow = gnt_count + 2;
        @(negedge clk);
        check("rd_resp_req_low", {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        lat      = 1;
        check("rd_valid_low", {31'd0, instr_valid}, 32'd0);
        check("rd_flush_req_low", {31'd0, imem_req}, 32'd0);
        expect_word(32'h100);
        wait_req(10, "rd_restart");
        check("rd_addr", imem_addr, 32'h100);
        wait_sb_empty(40, "rd_drain");

        // Redirect with a full FIFO
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        redirect  = 1'b0;
        g0        = gnt_count;
        gnt_allow = gnt_count + 2;
        repeat (8) @(negedge clk);
        check("full_req_idle", {31'd0, imem_req}, 32'd0);
        check("full_valid", {31'd0, instr_valid}, 32'd1);
        check("full_head_pc", instr_pc, 32'h10);
        check("full_head_instr", instr, memf(32'h10));
        check("full_words", gnt_count - g0, 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        gnt_allow   = gnt_count + 1;
        @(negedge clk);
        redirect = 1'b0;
        check("full_rd_valid_low", {31'd0, instr_valid}, 32'd0);
        check("full_rd_req", {31'd0, imem_req}, 32'd1);
        check("full_rd_addr", imem_addr, 32'h200);
        expect_word(32'h200);
        instr_ready = 1'b1;
        wait_sb_empty(40, "full_drain");

        // PC wrap, with low target bits ignored
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        gnt_allow = gnt_count + 2;
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0);
        wait_sb_empty(40, "wrap_drain");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
